// File: rtl/usb_uvc_payload_rx.sv
// UVC uncompressed payload receiver: strips packet headers, tracks FID/EOF framing, emits frame bytes.
// Optional statistics counters are enabled with `define UVC_RX_STATS_EN.
module usb_uvc_payload_rx #(
  parameter              FRAME_TYPE = "YUY2",
  parameter logic [13:0] FRAME_W    = 14'd320,
  parameter logic [13:0] FRAME_H    = 14'd240
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pkt_data,
  input  logic        pkt_valid,
  input  logic        pkt_last,
  output logic        vf_sof,
  output logic        vf_valid,
  output logic [7:0]  vf_byte,
  output logic        vf_eof,
  output logic        err_hdr,
  output logic        err_short,
  output logic        err_long,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);

  localparam logic [31:0] FRAME_BYTES = 32'(FRAME_W) * 32'(FRAME_H) * 32'd2;
  localparam logic        IS_MONO     = (FRAME_TYPE == "MONO");
  // MONO frames end on the last Y byte, which sits one before the final wire byte
  localparam logic [31:0] LAST_IDX    = IS_MONO ? (FRAME_BYTES - 32'd2) : (FRAME_BYTES - 32'd1);

  typedef enum logic [2:0] {
    S_HLEN = 3'd0,
    S_BFH  = 3'd1,
    S_SKIP = 3'd2,
    S_PAY  = 3'd3,
    S_DROP = 3'd4
  } state_t;

  state_t      state_r, state_s;
  logic [3:0]  skip_r, skip_s;
  logic [31:0] bcnt_r, bcnt_s;
  logic        synced_r, synced_s;
  logic        prev_fid_r, prev_fid_s;
  logic        prev_eof_r, prev_eof_s;
  logic        seen_r, seen_s;
  logic        sof_pend_r, sof_pend_s;
  logic        long_r, long_s;
  logic        cur_eof_r, cur_eof_s;
  logic        end_ok_s;
  logic        vf_sof_r, vf_sof_s;
  logic        vf_valid_r, vf_valid_s;
  logic [7:0]  vf_byte_r, vf_byte_s;
  logic        vf_eof_r, vf_eof_s;
  logic        err_hdr_r, err_hdr_s;
  logic        err_short_r, err_short_s;
  logic        err_long_r, err_long_s;

  // Per-byte packet parsing and frame tracking
  always_comb begin
    state_s     = state_r;
    skip_s      = skip_r;
    bcnt_s      = bcnt_r;
    synced_s    = synced_r;
    prev_fid_s  = prev_fid_r;
    prev_eof_s  = prev_eof_r;
    seen_s      = seen_r;
    sof_pend_s  = sof_pend_r;
    long_s      = long_r;
    cur_eof_s   = cur_eof_r;
    end_ok_s    = 1'b0;
    vf_sof_s    = 1'b0;
    vf_valid_s  = 1'b0;
    vf_byte_s   = 8'h00;
    vf_eof_s    = 1'b0;
    err_hdr_s   = 1'b0;
    err_short_s = 1'b0;
    err_long_s  = 1'b0;
    if (pkt_valid) begin
      case (state_r)
        S_HLEN: begin
          skip_s = pkt_data[3:0] - 4'd2;
          if (pkt_last) begin
            err_hdr_s = 1'b1;
            synced_s  = 1'b0;
            state_s   = S_HLEN;
          end else if ((pkt_data < 8'd2) || (pkt_data > 8'd12)) begin
            err_hdr_s = 1'b1;
            state_s   = S_DROP;
          end else begin
            state_s   = S_BFH;
          end
        end
        S_BFH: begin
          prev_fid_s = pkt_data[0];
          prev_eof_s = pkt_data[1];
          cur_eof_s  = pkt_data[1];
          seen_s     = 1'b1;
          if (pkt_data[6]) begin
            err_hdr_s = 1'b1;
            synced_s  = 1'b0;
            state_s   = pkt_last ? S_HLEN : S_DROP;
          end else begin
            // seen_r blocks a frame start on the first header after reset
            if (seen_r && ((pkt_data[0] != prev_fid_r) || (!synced_r && prev_eof_r))) begin
              err_short_s = synced_r && (bcnt_r < FRAME_BYTES);
              synced_s    = 1'b1;
              bcnt_s      = 32'd0;
              sof_pend_s  = 1'b1;
              long_s      = 1'b0;
            end else begin
              synced_s    = synced_r;
            end
            if (pkt_last) begin
              state_s = S_HLEN;
              if (skip_r != 4'd0) begin
                err_hdr_s = 1'b1;
                synced_s  = 1'b0;
              end else begin
                end_ok_s  = 1'b1;
              end
            end else if (skip_r != 4'd0) begin
              state_s = S_SKIP;
            end else begin
              state_s = S_PAY;
            end
          end
        end
        S_SKIP: begin
          skip_s = skip_r - 4'd1;
          if (pkt_last) begin
            state_s = S_HLEN;
            if (skip_r != 4'd1) begin
              err_hdr_s = 1'b1;
              synced_s  = 1'b0;
            end else begin
              end_ok_s  = 1'b1;
            end
          end else if (skip_r == 4'd1) begin
            state_s = S_PAY;
          end else begin
            state_s = S_SKIP;
          end
        end
        S_PAY: begin
          if (synced_r) begin
            if (bcnt_r < FRAME_BYTES) begin
              if (!IS_MONO || !bcnt_r[0]) begin
                vf_valid_s = 1'b1;
                vf_byte_s  = pkt_data;
                vf_sof_s   = sof_pend_r;
                sof_pend_s = 1'b0;
                vf_eof_s   = (bcnt_r == LAST_IDX);
              end else begin
                vf_valid_s = 1'b0;
              end
              bcnt_s = bcnt_r + 32'd1;
            end else if (!long_r) begin
              err_long_s = 1'b1;
              long_s     = 1'b1;
            end else begin
              err_long_s = 1'b0;
            end
          end else begin
            bcnt_s = bcnt_r;
          end
          if (pkt_last) begin
            state_s  = S_HLEN;
            end_ok_s = 1'b1;
          end else begin
            state_s  = S_PAY;
          end
        end
        S_DROP: begin
          state_s = pkt_last ? S_HLEN : S_DROP;
        end
        default: begin
          state_s = S_HLEN;
        end
      endcase
      // EOF closes the frame at the end of a well-formed packet
      if (end_ok_s && cur_eof_s) begin
        if (synced_s && (bcnt_s < FRAME_BYTES)) begin
          err_short_s = 1'b1;
        end else begin
          err_short_s = err_short_s;
        end
        synced_s   = 1'b0;
        prev_eof_s = 1'b1;
      end else begin
        prev_eof_s = prev_eof_s;
      end
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_HLEN;
      skip_r      <= 4'd0;
      bcnt_r      <= 32'd0;
      synced_r    <= 1'b0;
      prev_fid_r  <= 1'b0;
      prev_eof_r  <= 1'b0;
      seen_r      <= 1'b0;
      sof_pend_r  <= 1'b0;
      long_r      <= 1'b0;
      cur_eof_r   <= 1'b0;
      vf_sof_r    <= 1'b0;
      vf_valid_r  <= 1'b0;
      vf_byte_r   <= 8'h00;
      vf_eof_r    <= 1'b0;
      err_hdr_r   <= 1'b0;
      err_short_r <= 1'b0;
      err_long_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      skip_r      <= skip_s;
      bcnt_r      <= bcnt_s;
      synced_r    <= synced_s;
      prev_fid_r  <= prev_fid_s;
      prev_eof_r  <= prev_eof_s;
      seen_r      <= seen_s;
      sof_pend_r  <= sof_pend_s;
      long_r      <= long_s;
      cur_eof_r   <= cur_eof_s;
      vf_sof_r    <= vf_sof_s;
      vf_valid_r  <= vf_valid_s;
      vf_byte_r   <= vf_byte_s;
      vf_eof_r    <= vf_eof_s;
      err_hdr_r   <= err_hdr_s;
      err_short_r <= err_short_s;
      err_long_r  <= err_long_s;
    end
  end

  assign vf_sof    = vf_sof_r;
  assign vf_valid  = vf_valid_r;
  assign vf_byte   = vf_byte_r;
  assign vf_eof    = vf_eof_r;
  assign err_hdr   = err_hdr_r;
  assign err_short = err_short_r;
  assign err_long  = err_long_r;

`ifdef UVC_RX_STATS_EN
  logic [15:0] frame_cnt_r;
  logic [15:0] err_cnt_r;

  // Frame counter wraps; error counter saturates and counts coincident errors once
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_r <= 16'h0000;
      err_cnt_r   <= 16'h0000;
    end else begin
      if (vf_eof_s) begin
        frame_cnt_r <= frame_cnt_r + 16'h0001;
      end else begin
        frame_cnt_r <= frame_cnt_r;
      end
      if ((err_hdr_s || err_short_s || err_long_s) && (err_cnt_r != 16'hFFFF)) begin
        err_cnt_r <= err_cnt_r + 16'h0001;
      end else begin
        err_cnt_r <= err_cnt_r;
      end
    end
  end

  assign frame_cnt = frame_cnt_r;
  assign err_cnt   = err_cnt_r;
`else
  assign frame_cnt = 16'h0000;
  assign err_cnt   = 16'h0000;
`endif

endmodule

// File: tb/tb_usb_uvc_payload_rx.sv
// Directed bench for usb_uvc_payload_rx with a 4x2 frame (16 bytes), YUY2 and MONO instances.
module tb_usb_uvc_payload_rx;

`ifdef UVC_RX_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pkt_data;
  logic        pkt_valid;
  logic        pkt_last;

  logic        vf_sof, vf_valid, vf_eof, err_hdr, err_short, err_long;
  logic [7:0]  vf_byte;
  logic [15:0] frame_cnt, err_cnt;

  logic        m_sof, m_valid, m_eof, m_hdr, m_short, m_long;
  logic [7:0]  m_byte;
  logic [15:0] m_frame_cnt, m_err_cnt;

  int tests = 0;
  int fails = 0;

  int n_val, n_sof, n_eof, n_hdr, n_short, n_long, n_both;
  int sof_b, eof_b, last_b;
  int m_val, m_eof_n, m_sof_n, m_eof_b, m_sum;

  always #5 clk = ~clk;

  usb_uvc_payload_rx #(.FRAME_TYPE("YUY2"), .FRAME_W(14'd4), .FRAME_H(14'd2)) dut (
    .clk(clk), .rst(rst), .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_last(pkt_last),
    .vf_sof(vf_sof), .vf_valid(vf_valid), .vf_byte(vf_byte), .vf_eof(vf_eof),
    .err_hdr(err_hdr), .err_short(err_short), .err_long(err_long),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  usb_uvc_payload_rx #(.FRAME_TYPE("MONO"), .FRAME_W(14'd4), .FRAME_H(14'd2)) dut_m (
    .clk(clk), .rst(rst), .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_last(pkt_last),
    .vf_sof(m_sof), .vf_valid(m_valid), .vf_byte(m_byte), .vf_eof(m_eof),
    .err_hdr(m_hdr), .err_short(m_short), .err_long(m_long),
    .frame_cnt(m_frame_cnt), .err_cnt(m_err_cnt)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_val = 0; n_sof = 0; n_eof = 0; n_hdr = 0; n_short = 0; n_long = 0; n_both = 0;
    sof_b = -1; eof_b = -1; last_b = -1;
    m_val = 0; m_eof_n = 0; m_sof_n = 0; m_eof_b = -1; m_sum = 0;
  endtask

  task automatic sample();
    if (vf_valid) begin n_val++; last_b = int'(vf_byte); end
    if (vf_sof) begin n_sof++; sof_b = int'(vf_byte); end
    if (vf_eof) begin n_eof++; eof_b = int'(vf_byte); end
    if (err_hdr) n_hdr++;
    if (err_short) n_short++;
    if (err_long) n_long++;
    if (err_hdr && err_short) n_both++;
    if (m_valid) begin m_val++; m_sum += int'(m_byte); end
    if (m_sof) m_sof_n++;
    if (m_eof) begin m_eof_n++; m_eof_b = int'(m_byte); end
  endtask

  task automatic put(input logic [7:0] d, input logic l);
    pkt_data  = d;
    pkt_valid = 1'b1;
    pkt_last  = l;
    @(posedge clk);
    #1;
    sample();
  endtask

  task automatic idle();
    pkt_valid = 1'b0;
    pkt_last  = 1'b0;
    @(posedge clk);
    #1;
    sample();
  endtask

  task automatic send_pkt(input int hle, input logic [7:0] bfh, input int npay, input logic [7:0] base);
    int skip;
    skip = (hle >= 2 && hle <= 12) ? hle - 2 : 0;
    put(8'(hle), 1'b0);
    put(bfh, (skip == 0) && (npay == 0));
    for (int i = 0; i < skip; i++) put(8'hEE, (i == skip - 1) && (npay == 0));
    for (int i = 0; i < npay; i++) put(8'(base + 8'(i)), i == npay - 1);
    idle();
  endtask

  initial begin
    rst = 1'b1; pkt_data = 8'h00; pkt_valid = 1'b0; pkt_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst vf_valid", int'(vf_valid), 0);
    chk("rst vf_sof", int'(vf_sof), 0);
    chk("rst vf_eof", int'(vf_eof), 0);
    chk("rst vf_byte", int'(vf_byte), 0);
    chk("rst errs", int'({err_hdr, err_short, err_long}), 0);
    chk("rst frame_cnt", int'(frame_cnt), 0);
    chk("rst err_cnt", int'(err_cnt), 0);
    rst = 1'b0;

    clr(); send_pkt(2, 8'h80, 8, 8'h10);
    chk("first pkt no frame", n_val, 0);

    clr(); send_pkt(2, 8'h81, 10, 8'h20);
    chk("toggle start count", n_val, 10);
    chk("toggle start sof", n_sof, 1);
    chk("sof byte", sof_b, 32'h20);

    clr(); send_pkt(2, 8'h81, 8, 8'h40);
    chk("cont count", n_val, 6);
    chk("cont no sof", n_sof, 0);
    chk("eof count", n_eof, 1);
    chk("eof byte", eof_b, 32'h45);
    chk("err_long once", n_long, 1);
    chk("frame_cnt 1", int'(frame_cnt), STATS * 1);

    clr(); send_pkt(2, 8'h83, 0, 8'h00);
    chk("zero pay no short", n_short, 0);
    chk("zero pay no hdr", n_hdr, 0);

    clr(); send_pkt(2, 8'h81, 6, 8'h60);
    chk("post eof start sof", n_sof, 1);
    chk("post eof count", n_val, 6);

    clr(); send_pkt(2, 8'h80, 4, 8'h70);
    chk("short on toggle", n_short, 1);
    chk("short new sof byte", sof_b, 32'h70);
    chk("short new count", n_val, 4);

    clr(); send_pkt(12, 8'h80, 4, 8'h80);
    chk("skip count", n_val, 4);
    chk("skip last byte", last_b, 32'h83);
    chk("skip no hdr", n_hdr, 0);

    clr(); send_pkt(1, 8'h80, 4, 8'h90); send_pkt(13, 8'h80, 3, 8'h90);
    chk("bad hle hdr", n_hdr, 2);
    chk("bad hle dropped", n_val, 0);

    clr(); send_pkt(2, 8'hC0, 8, 8'h30);
    chk("bfh err hdr", n_hdr, 1);
    chk("bfh err no data", n_val, 0);
    chk("bfh err no short", n_short, 0);

    clr(); send_pkt(2, 8'h80, 4, 8'h30);
    chk("no resync same fid", n_val, 0);

    clr(); send_pkt(2, 8'h81, 16, 8'hA0);
    chk("full count", n_val, 16);
    chk("full sof", n_sof, 1);
    chk("full eof byte", eof_b, 32'hAF);
    chk("full no long", n_long, 0);
    chk("frame_cnt 2", int'(frame_cnt), STATS * 2);

    clr();
    send_pkt(2, 8'h80, 3, 8'hB0);
    put(8'h04, 1'b0); put(8'h81, 1'b1); idle();
    send_pkt(2, 8'h81, 2, 8'hB8);
    chk("trunc count", n_val, 3);
    chk("trunc both", n_both, 1);
    chk("trunc hdr", n_hdr, 1);
    chk("err_cnt 6", int'(err_cnt), STATS * 6);

    put(8'h02, 1'b0); put(8'h80, 1'b0);
    for (int i = 0; i < 5; i++) put(8'(8'hD0 + 8'(i)), 1'b0);
    chk("pre rst emitting", int'(vf_valid), 1);
    rst = 1'b1; pkt_valid = 1'b0; pkt_last = 1'b0;
    @(posedge clk);
    #1;
    chk("mid rst vf_valid", int'(vf_valid), 0);
    chk("mid rst vf_byte", int'(vf_byte), 0);
    chk("mid rst eof/errs", int'({vf_eof, err_hdr, err_short, err_long}), 0);
    chk("mid rst err_cnt", int'(err_cnt), 0);
    rst = 1'b0;

    clr(); send_pkt(2, 8'h80, 4, 8'h30);
    chk("post rst no frame", n_val, 0);
    chk("post rst mono no frame", m_val, 0);

    clr(); send_pkt(2, 8'h81, 16, 8'hC0);
    chk("post rst frame", n_val, 16);
    chk("mono count", m_val, 8);
    chk("mono sof", m_sof_n, 1);
    chk("mono eof", m_eof_n, 1);
    chk("mono eof byte", m_eof_b, 32'hCE);
    chk("mono sum", m_sum, 1592);
    chk("frame_cnt post rst", int'(frame_cnt), STATS * 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
